// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues reads to a stallable instruction memory and
// drives the F/D latch. Optional WAIT-cycle counter under `FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirectEn,
    input  logic [15:0] redirectPC,
    input  logic [15:0] memInstr,
    input  logic        memDone,
    input  logic        memErr,
    output logic        memRd,
    output logic [15:0] memAddr,
    output logic [15:0] instructionF,
    output logic [15:0] incPCF,
    output logic        instrValidF,
    output logic        errF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] memWaitCnt
`endif
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, HALTED} state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic        pend, pend_n;
    logic [15:0] tgt, tgt_n;
    logic        cap;
    logic [15:0] hbuf_instr;
    logic [15:0] hbuf_inc;
    logic        hbuf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            pend       <= 1'b0;
            tgt        <= '0;
            hbuf_instr <= NOP_INSTR;
            hbuf_inc   <= '0;
            hbuf_err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            pend  <= pend_n;
            tgt   <= tgt_n;
            if (cap) begin
                hbuf_instr <= memInstr;
                hbuf_inc   <= pc + 16'd2;
                hbuf_err   <= memErr | pc[0];
            end
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_n       = pend;
        tgt_n        = tgt;
        cap          = 1'b0;
        memRd        = 1'b0;
        memAddr      = pc;
        instructionF = NOP_INSTR;
        incPCF       = pc + 16'd2;
        instrValidF  = 1'b0;
        errF         = 1'b0;

        if (rst) begin
            incPCF = RESET_PC + 16'd2;
        end else begin
            case (state)
                REQ, WAIT: begin
                    memRd = 1'b1;
                    if (pend) begin
                        // In-flight access belongs to the old path: drop its data.
                        if (redirectEn)
                            tgt_n = redirectPC;
                        if (memDone) begin
                            pc_n    = redirectEn ? redirectPC : tgt;
                            pend_n  = 1'b0;
                            state_n = REQ;
                        end
                    end else if (redirectEn) begin
                        if (state == REQ || memDone) begin
                            pc_n    = redirectPC;
                            state_n = REQ;
                        end else begin
                            pend_n = 1'b1;
                            tgt_n  = redirectPC;
                        end
                    end else if (memDone) begin
                        instructionF = memInstr;
                        instrValidF  = 1'b1;
                        errF         = memErr | pc[0];
                        if (stallF) begin
                            cap     = 1'b1;
                            state_n = HOLD;
                        end else begin
                            pc_n    = pc + 16'd2;
                            state_n = (memInstr[15:11] == HALT_OPCODE) ? HALTED : REQ;
                        end
                    end else begin
                        state_n = WAIT;
                    end
                end

                HOLD: begin
                    if (redirectEn) begin
                        pc_n    = redirectPC;
                        state_n = REQ;
                    end else begin
                        instructionF = hbuf_instr;
                        incPCF       = hbuf_inc;
                        errF         = hbuf_err;
                        instrValidF  = 1'b1;
                        if (!stallF) begin
                            pc_n    = pc + 16'd2;
                            state_n = (hbuf_instr[15:11] == HALT_OPCODE) ? HALTED : REQ;
                        end
                    end
                end

                HALTED: begin
                    if (redirectEn) begin
                        pc_n    = redirectPC;
                        state_n = REQ;
                    end
                end

                default: state_n = REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            memWaitCnt <= '0;
        else if (state == WAIT && memWaitCnt != 16'hFFFF)
            memWaitCnt <= memWaitCnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-randomized memory, a program-order
// reference model feeding an expectation queue, and a monitor checking the F/D outputs.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [4:0]  HALT     = 5'b00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        redirectEn = 1'b0;
    logic [15:0] redirectPC = '0;
    logic [15:0] memInstr = '0;
    logic        memDone = 1'b0;
    logic        memErr = 1'b0;
    logic        memRd;
    logic [15:0] memAddr;
    logic [15:0] instructionF;
    logic [15:0] incPCF;
    logic        instrValidF;
    logic        errF;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] memWaitCnt;
`endif

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .NOP_INSTR  (NOP),
        .HALT_OPCODE(HALT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .redirectEn  (redirectEn),
        .redirectPC  (redirectPC),
        .memInstr    (memInstr),
        .memDone     (memDone),
        .memErr      (memErr),
        .memRd       (memRd),
        .memAddr     (memAddr),
        .instructionF(instructionF),
        .incPCF      (incPCF),
        .instrValidF (instrValidF),
        .errF        (errF)
`ifdef FETCH_PERF_CNT_EN
        ,
        .memWaitCnt  (memWaitCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] inc;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] ovr[logic [15:0]];
    logic [31:0] seed;
    int          n_vec = 0;
    int          n_fail = 0;
    bit          halted = 1'b0;
    bit          started = 1'b0;
    bit          cur_first = 1'b0;
    int          lat_mode = -1;

    // memory-side bookkeeping, owned by the driver
    bit prev_rd = 1'b0, prev_done = 1'b0, prev_first = 1'b0, prev_redir = 1'b0;
    int lat_left = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] h;
        if (ovr.exists(a)) return ovr[a];
        h = ({16'd0, a} ^ seed) * 32'h9E3779B1;
        return h[31:16];
    endfunction

    function automatic logic err_word(input logic [15:0] a);
        logic [31:0] h;
        h = ({16'd0, a} + seed) * 32'h85EBCA6B;
        return (h[31:28] == 4'h0);
    endfunction

    // Architectural expectation for the instruction fetched from address a.
    function automatic exp_t mk_exp(input logic [15:0] a);
        exp_t e;
        e.addr  = a;
        e.instr = mem_word(a);
        e.inc   = a + 16'd2;
        e.err   = err_word(a) | a[0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // One clock of stimulus. st/rd: 0 = off, 1 = forced on, 2 = random.
    task automatic step(input int st, input int rd, input logic [15:0] tgt, input bit do_rst);
        bit          rdn, first, done, redir;
        logic [15:0] t;
        int          r;
        @(negedge clk);
        rst = do_rst;
        #1;
        rdn   = memRd;
        first = rdn && (!prev_rd || prev_done || (prev_first && prev_redir));
        if (first) begin
            if (lat_mode >= 0) lat_left = lat_mode;
            else begin
                r = $urandom_range(0, 7);
                lat_left = (r < 4) ? 0 : r - 3;
            end
        end
        done = rdn && (lat_left == 0);
        if (rdn && lat_left > 0) lat_left--;
        memDone  = done;
        memInstr = done ? mem_word(memAddr) : 16'($urandom);
        memErr   = done ? err_word(memAddr) : 1'($urandom);
        stallF   = (st == 2) ? ($urandom_range(0, 3) == 0) : (st == 1);
        redir    = !do_rst && ((rd == 1) ||
                   (rd == 2 && (halted ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0))));
        t = tgt;
        if (rd == 2) begin
            r = $urandom_range(0, 15);
            t = 16'($urandom);
            if (r == 0) t = 16'hFFFE;
            else if (r != 1) t[0] = 1'b0;
        end
        redirectEn = redir;
        redirectPC = redir ? t : 16'($urandom);
        if (do_rst) begin
            expq.delete();
            expq.push_back(mk_exp(RESET_PC));
            halted = 1'b0;
        end else if (redir) begin
            expq.delete();
            expq.push_back(mk_exp(t));
            halted = 1'b0;
        end
        cur_first  = first;
        prev_rd    = rdn;
        prev_done  = done;
        prev_first = first;
        prev_redir = redir;
        started    = 1'b1;
    endtask

    // Monitor: samples mid-cycle, after the driver has settled this cycle's inputs.
    initial begin : monitor
        exp_t        e;
        bit          was_rst = 1'b0, prev_rd_m = 1'b0, hold_pend = 1'b0, wvalid = 1'b0;
        logic [15:0] prev_addr = '0, hold_i = '0, hold_inc = '0, wcnt = '0;
        logic        hold_e = 1'b0;
        int          idle = 0;
        forever begin
            @(negedge clk);
            #3;
            if (started) begin
                if (rst) begin
                    chk("reset_outputs", 64'({memRd, instrValidF, errF, instructionF, incPCF}),
                        64'({1'b0, 1'b0, 1'b0, NOP, RESET_PC + 16'd2}));
                    was_rst = 1'b1; prev_rd_m = 1'b0; hold_pend = 1'b0; idle = 0;
                end else begin
                    if (was_rst)
                        chk("fetch_after_reset", 64'({memRd, memAddr}), 64'({1'b1, RESET_PC}));
                    if (!instrValidF)
                        chk("nop_when_invalid", 64'({instructionF, errF}), 64'({NOP, 1'b0}));
                    if (redirectEn)
                        chk("redirect_squash", 64'(instrValidF), 64'(1'b0));
                    if (halted)
                        chk("halted_idle", 64'({memRd, instrValidF}), 64'({1'b0, 1'b0}));
                    if (memRd && prev_rd_m && !cur_first)
                        chk("addr_stable", 64'(memAddr), 64'(prev_addr));
                    if (hold_pend && !redirectEn)
                        chk("stall_hold", 64'({instrValidF, memRd, instructionF, incPCF, errF}),
                            64'({1'b1, 1'b0, hold_i, hold_inc, hold_e}));
                    if (instrValidF && !stallF && !redirectEn) begin
                        idle = 0;
                        if (expq.size() == 0) begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL unexpected_instr: got %h at incPC %h, expected none", instructionF, incPCF);
                        end else begin
                            e = expq.pop_front();
                            chk("fetch_data", 64'({instructionF, incPCF, errF}), 64'({e.instr, e.inc, e.err}));
                            if (memRd)
                                chk("fetch_addr", 64'(memAddr), 64'(e.addr));
                            if (e.instr[15:11] == HALT) halted = 1'b1;
                            else expq.push_back(mk_exp(e.addr + 16'd2));
                        end
                    end else if (expq.size() != 0 && !redirectEn) begin
                        idle++;
                        if (idle > 150) begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL progress_timeout: got no fetch of %h in 150 cycles, expected one", expq[0].addr);
                            idle = 0;
                        end
                    end
                    if (redirectEn) idle = 0;
                    hold_pend = instrValidF && stallF && !redirectEn;
                    hold_i = instructionF; hold_inc = incPCF; hold_e = errF;
                    prev_rd_m = memRd; prev_addr = memAddr; was_rst = 1'b0;
                end
`ifdef FETCH_PERF_CNT_EN
                if (wvalid) chk("wait_count", 64'(memWaitCnt), 64'(wcnt));
`endif
                if (rst) begin
                    wcnt = '0;
                    wvalid = 1'b1;
                end else if (memRd && !cur_first && wcnt != 16'hFFFF) begin
                    wcnt = wcnt + 16'd1;
                end
            end
        end
    end

    initial begin : stimulus
        seed = $urandom;
        ovr[16'h0000] = 16'h4000; ovr[16'h0002] = 16'h4800; ovr[16'h0004] = 16'h5000;
        ovr[16'h0010] = 16'h6000; ovr[16'h0012] = 16'hA123; ovr[16'h0014] = 16'h6800;
        ovr[16'h0020] = 16'h7000; ovr[16'h0100] = 16'h6000; ovr[16'h0102] = 16'h0000;
        ovr[16'h0040] = 16'h6000; ovr[16'hFFFE] = 16'h6000;

        step(0, 0, 16'h0, 1'b1);
        step(0, 0, 16'h0, 1'b1);
        lat_mode = 0;
        repeat (3) step(0, 0, 16'h0, 1'b0);          // 0x4000, 0x4800, 0x5000 back to back
        lat_mode = 3;
        step(0, 1, 16'h0010, 1'b0);
        repeat (4) step(0, 0, 16'h0, 1'b0);          // three NOP cycles, then 0x0010
        lat_mode = 0;
        step(1, 0, 16'h0, 1'b0);                     // 0xA123 stalled for two cycles
        step(1, 0, 16'h0, 1'b0);
        step(0, 0, 16'h0, 1'b0);
        step(0, 0, 16'h0, 1'b0);
        step(0, 1, 16'h0020, 1'b0);
        lat_mode = 4;
        step(0, 0, 16'h0, 1'b0);
        step(0, 1, 16'h0100, 1'b0);                  // redirect while 0x0020 is in flight
        repeat (3) step(0, 0, 16'h0, 1'b0);
        lat_mode = 0;
        repeat (8) step(0, 0, 16'h0, 1'b0);          // 0x0100, HALT at 0x0102, then idle
        step(0, 1, 16'h0040, 1'b0);
        step(0, 0, 16'h0, 1'b0);
        step(0, 1, 16'hFFFE, 1'b0);
        step(0, 0, 16'h0, 1'b0);                     // incPCF wraps to 0x0000
        step(0, 0, 16'h0, 1'b0);
        step(0, 0, 16'h0, 1'b1);
        lat_mode = 5;
        repeat (8) step(0, 0, 16'h0, 1'b0);          // five WAIT cycles on one access
        lat_mode = -1;

        for (int i = 0; i < 3000; i++)
            step(2, 2, 16'h0, ($urandom_range(0, 199) == 0));

        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
